gemm_sequencer: RTL

GEMM_SEQUENCER -- requirements
Module: gemm_sequencer

---
 rtl/GEMM_pkg.sv | 24 ++
 rtl/gemm_seq_out_fifo.sv | 65 ++++++
 rtl/gemm_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/GEMM_pkg.sv
// Shared types for the GEMM sequencer: the command bus into the systolic array
// and the sequencer state encoding.
package GEMM_pkg;

  typedef enum logic [1:0] {
    CMD_NONE          = 2'd0,
    CMD_WRITE_WEIGHTS = 2'd1,
    CMD_STREAM        = 2'd2
  } command_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FLUSH  = 3'd4
  } seq_state_t;

  // Width of a row counter that must reach maxRows without wrapping.
  function automatic int rowCountWidth(input int maxRows);
    return $clog2(maxRows + 1);
  endfunction

endpackage

// File: rtl/gemm_seq_out_fifo.sv
// First-word-fall-through result buffer: one row of data plus an end-of-job flag
// per entry. A push into a full buffer is accepted only when a pop frees a slot.
module gemm_seq_out_fifo #(
  parameter int DATA_W         = 16,
  parameter int OUT_FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_last,
  output logic              o_empty,
  output logic              o_full
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);

  logic [DATA_W-1:0]         r_data [OUT_FIFO_DEPTH];
  logic [OUT_FIFO_DEPTH-1:0] r_lastFlag;
  logic [AW-1:0]             r_wrPtr;
  logic [AW-1:0]             r_rdPtr;
  logic [AW:0]               r_count;
  logic                      w_doPush;
  logic                      w_doPop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == (AW+1)'(OUT_FIFO_DEPTH));
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_data   = r_data[r_rdPtr];
  assign o_last   = !o_empty && r_lastFlag[r_rdPtr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_lastFlag <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr             <= r_wrPtr + AW'(1);
        r_lastFlag[r_wrPtr] <= i_last;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: it is only observable through a valid entry.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_data[r_wrPtr] <= i_data;
    end
  end

endmodule

// File: rtl/gemm_sequencer.sv
// Feeds one job (a weight matrix plus a stream of activation rows) through a
// systolic GEMM array and buffers the result rows behind a ready/valid output.
module gemm_sequencer
  import GEMM_pkg::*;
#(
  parameter int SA_SIZE                = 2,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int MAX_ROWS               = 16,
  parameter int OUT_FIFO_DEPTH         = 4,
  localparam int W  = WEIGHT_ACTIVATION_SIZE,
  localparam int RW = rowCountWidth(MAX_ROWS)
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic                                start_valid,
  output logic                                start_ready,
  input  logic [SA_SIZE-1:0][SA_SIZE-1:0][W-1:0] job_weights,
  input  logic [RW-1:0]                       job_num_rows,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [SA_SIZE-1:0][W-1:0]           in_row,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [SA_SIZE-1:0][W-1:0]           out_row,
  output logic                                out_last,
  output command_t                            gemm_cmd,
  output logic [SA_SIZE-1:0][SA_SIZE-1:0][W-1:0] gemm_weights,
  output logic [SA_SIZE-1:0][W-1:0]           gemm_activations,
  input  logic [SA_SIZE-1:0][W-1:0]           gemm_outputs,
  input  logic                                gemm_output_valid,
  output logic                                busy,
  output logic                                done
);

  seq_state_t                        r_state;
  logic [SA_SIZE-1:0][SA_SIZE-1:0][W-1:0] r_weights;
  logic [RW-1:0]                     r_numRows;
  logic [RW-1:0]                     r_rowsIn;
  logic [RW-1:0]                     r_rowsOut;
  logic                              r_done;

  logic w_fifoEmpty;
  logic w_fifoFull;
  logic w_fifoLast;
  logic w_pop;
  logic w_streamOk;
  logic w_accept;
  logic w_drainStep;
  logic w_push;
  logic w_pushLast;
  logic [SA_SIZE*W-1:0] w_fifoData;

  // The array only advances on a stream cycle, so it is held whenever the
  // buffer has no room for a result that might emerge this cycle.
  always_comb begin
    w_pop       = !w_fifoEmpty && out_ready;
    w_streamOk  = !w_fifoFull || w_pop;
    w_accept    = (r_state == STREAM) && in_valid && w_streamOk;
    w_drainStep = (r_state == DRAIN) && w_streamOk && (r_rowsOut < r_numRows);

    gemm_cmd = CMD_NONE;
    if (r_state == LOAD_W) begin
      gemm_cmd = CMD_WRITE_WEIGHTS;
    end else if (w_accept || w_drainStep) begin
      gemm_cmd = CMD_STREAM;
    end

    gemm_activations = w_accept ? in_row : '0;
    w_push     = gemm_output_valid && (gemm_cmd == CMD_STREAM) && (r_rowsOut < r_numRows);
    w_pushLast = ((r_rowsOut + RW'(1)) == r_numRows);
  end

  assign in_ready     = w_accept;
  assign start_ready  = (r_state == IDLE);
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign gemm_weights = r_weights;
  assign out_valid    = !w_fifoEmpty;
  assign out_row      = w_fifoData;
  assign out_last     = w_fifoLast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_weights <= '0;
      r_numRows <= '0;
      r_rowsIn  <= '0;
      r_rowsOut <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) begin
        r_rowsOut <= r_rowsOut + RW'(1);
      end
      if (w_accept) begin
        r_rowsIn <= r_rowsIn + RW'(1);
      end
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_weights <= job_weights;
            r_numRows <= job_num_rows;
            r_rowsIn  <= '0;
            r_rowsOut <= '0;
            r_state   <= (job_num_rows == '0) ? FLUSH : LOAD_W;
          end
        end
        LOAD_W: r_state <= STREAM;
        STREAM: begin
          if (w_accept && ((r_rowsIn + RW'(1)) == r_numRows)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          // Also covers an array that delivered every result while still streaming.
          if ((r_rowsOut == r_numRows) || (w_push && w_pushLast)) begin
            r_state <= FLUSH;
          end
        end
        FLUSH: begin
          if (w_fifoEmpty) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  gemm_seq_out_fifo #(
    .DATA_W         (SA_SIZE * W),
    .OUT_FIFO_DEPTH (OUT_FIFO_DEPTH)
  ) u_outFifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (gemm_outputs),
    .i_last  (w_pushLast),
    .i_pop   (w_pop),
    .o_data  (w_fifoData),
    .o_last  (w_fifoLast),
    .o_empty (w_fifoEmpty),
    .o_full  (w_fifoFull)
  );

endmodule
